vga_rx_capture: RTL and testbench

VGA_RX_CAPTURE -- requirements
Module: vga_rx_capture

---
 rtl/vga_rx_capture.sv | 195 +++++++++++++++++++
 tb/tb_vga_rx_capture.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_rx_capture.sv
// VGA receive-side crop-window capture.
// Measures the incoming raster, locks to it and forwards windowed pixels.
module vga_rx_capture (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        rgb_valid,
  input  logic [15:0] rgb,
  input  logic        cap_en,
  input  logic [9:0]  win_x,
  input  logic [9:0]  win_y,
  input  logic [9:0]  win_w,
  input  logic [9:0]  win_h,
  output logic [15:0] cap_data,
  output logic        cap_valid,
  output logic        cap_sof,
  output logic        cap_eol,
  output logic        cap_eof,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [11:0] h_active,
  output logic [11:0] v_active,
  output logic        locked,
  output logic        fmt_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_VS = 2'd1;
  localparam logic [1:0] MEASURE = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;

  logic [1:0]  state;
  logic        s_hs, s_vs, s_de, p_hs, p_vs, p_de;
  logic [15:0] s_rgb;
  logic [11:0] col, line;
  logic [9:0]  sh_x, sh_y, sh_w, sh_h;
  logic [11:0] meas_h;
  logic        meas_arm, meas_have, meas_bad;

  logic        fs, de_rise, de_fall, hs_rise;
  logic [11:0] col_cur, line_cur;
  logic [11:0] wx, wy, ww, wh, ha, va;
  logic [11:0] x_lo, y_lo, x_hi, y_hi, x_end, y_end;
  logic        full, empty, in_win, lock_now;
  logic        err_len, err_frm, cap_ok, cap;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  assign fs      = s_vs & ~p_vs;
  assign de_rise = s_de & ~p_de;
  assign de_fall = ~s_de & p_de;
  assign hs_rise = s_hs & ~p_hs;
  assign locked  = (state == LOCKED);

  always_comb begin
    col_cur  = de_rise ? '0 : col;
    line_cur = fs ? '0 : line;
    // the window presented at frame start governs that whole frame
    wx = fs ? {2'b0, win_x} : {2'b0, sh_x};
    wy = fs ? {2'b0, win_y} : {2'b0, sh_y};
    ww = fs ? {2'b0, win_w} : {2'b0, sh_w};
    wh = fs ? {2'b0, win_h} : {2'b0, sh_h};
    lock_now = cap_en && (state == MEASURE) && fs && meas_arm &&
               meas_have && !meas_bad && (line != '0);
    ha = lock_now ? meas_h : h_active;
    va = lock_now ? line : v_active;
    full  = (ww == '0) || (wh == '0);
    x_hi  = wx + ww - 12'd1;
    y_hi  = wy + wh - 12'd1;
    x_lo  = full ? '0 : wx;
    y_lo  = full ? '0 : wy;
    x_end = (full || x_hi >= ha) ? ha - 12'd1 : x_hi;
    y_end = (full || y_hi >= va) ? va - 12'd1 : y_hi;
    empty = !full && (wx >= ha || wy >= va);
    in_win = !empty &&
             col_cur >= x_lo && col_cur <= x_end &&
             line_cur >= y_lo && line_cur <= y_end;
    err_len = (state == LOCKED) && de_fall && (col != h_active);
    err_frm = (state == LOCKED) && fs && (line != v_active);
    cap_ok  = cap_en && (lock_now || (state == LOCKED && !err_frm));
    cap     = cap_ok && s_de && in_win;
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      {s_hs, s_vs, s_de, p_hs, p_vs, p_de} <= '0;
      s_rgb <= '0;
      col   <= '0;
      line  <= '0;
      sh_x  <= '0;
      sh_y  <= '0;
      sh_w  <= '0;
      sh_h  <= '0;
    end else begin
      s_hs  <= hsync;
      s_vs  <= vsync;
      s_de  <= rgb_valid;
      s_rgb <= rgb;
      p_hs  <= s_hs;
      p_vs  <= s_vs;
      p_de  <= s_de;
      if (fs) begin
        sh_x <= win_x;
        sh_y <= win_y;
        sh_w <= win_w;
        sh_h <= win_h;
      end
      if (s_de)         col <= sat_inc(col_cur);
      else if (hs_rise) col <= '0;
      if (fs)           line <= '0;
      else if (de_fall) line <= sat_inc(line);
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      meas_h    <= '0;
      meas_arm  <= 1'b0;
      meas_have <= 1'b0;
      meas_bad  <= 1'b0;
      h_active  <= '0;
      v_active  <= '0;
      fmt_err   <= 1'b0;
    end else begin
      fmt_err <= cap_en && (err_len || err_frm);
      if (!cap_en) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: state <= WAIT_VS;
          WAIT_VS: if (fs) begin
            state     <= MEASURE;
            meas_arm  <= 1'b1;
            meas_have <= 1'b0;
            meas_bad  <= 1'b0;
          end
          MEASURE: if (lock_now) begin
            state    <= LOCKED;
            h_active <= meas_h;
            v_active <= line;
          end else if (fs) begin
            meas_arm  <= 1'b1;
            meas_have <= 1'b0;
            meas_bad  <= 1'b0;
          end else if (de_fall && meas_arm) begin
            if (!meas_have) begin
              meas_h    <= col;
              meas_have <= 1'b1;
            end else if (col != meas_h) begin
              meas_bad <= 1'b1;
            end
          end
          LOCKED: if (err_frm) begin
            state     <= MEASURE;
            meas_arm  <= 1'b1;
            meas_have <= 1'b0;
            meas_bad  <= 1'b0;
          end else if (err_len) begin
            // partial frame is useless for measuring; wait for next vsync
            state    <= MEASURE;
            meas_arm <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      cap_valid <= 1'b0;
      cap_sof   <= 1'b0;
      cap_eol   <= 1'b0;
      cap_eof   <= 1'b0;
      cap_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
    end else begin
      cap_valid <= cap;
      cap_sof   <= cap && col_cur == x_lo && line_cur == y_lo;
      cap_eol   <= cap && col_cur == x_end;
      cap_eof   <= cap && col_cur == x_end && line_cur == y_end;
      if (cap) begin
        cap_data <= s_rgb;
        pix_x    <= col_cur;
        pix_y    <= line_cur;
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_capture.sv
// Directed bench for vga_rx_capture.
// Drives 16x8 rasters, checks lock, windowing, errors and reset.
module tb_vga_rx_capture;

  logic        vga_clk = 1'b0;
  logic        sys_rst, hsync, vsync, rgb_valid, cap_en;
  logic [15:0] rgb;
  logic [9:0]  win_x, win_y, win_w, win_h;
  logic [15:0] cap_data;
  logic        cap_valid, cap_sof, cap_eol, cap_eof;
  logic [11:0] pix_x, pix_y, h_active, v_active;
  logic        locked, fmt_err;

  vga_rx_capture dut (
    .vga_clk  (vga_clk),
    .sys_rst  (sys_rst),
    .hsync    (hsync),
    .vsync    (vsync),
    .rgb_valid(rgb_valid),
    .rgb      (rgb),
    .cap_en   (cap_en),
    .win_x    (win_x),
    .win_y    (win_y),
    .win_w    (win_w),
    .win_h    (win_h),
    .cap_data (cap_data),
    .cap_valid(cap_valid),
    .cap_sof  (cap_sof),
    .cap_eol  (cap_eol),
    .cap_eof  (cap_eof),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .h_active (h_active),
    .v_active (v_active),
    .locked   (locked),
    .fmt_err  (fmt_err)
  );

  always #5 vga_clk = ~vga_clk;

  int n_chk = 0;
  int n_err = 0;
  int n_valid, n_sof, n_eol, n_eof, n_fe;
  int sx, sy, ex, ey, eol_x, min_x, max_x, min_y, max_y;
  logic [15:0] d1, d2;

  always @(posedge vga_clk) begin
    d1 <= rgb;
    d2 <= d1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    n_valid = 0; n_sof = 0; n_eol = 0; n_eof = 0; n_fe = 0;
    sx = -1; sy = -1; ex = -1; ey = -1; eol_x = -1;
    min_x = 9999; max_x = -1; min_y = 9999; max_y = -1;
  endtask

  always @(negedge vga_clk) begin
    if (fmt_err) n_fe++;
    if (cap_valid) begin
      n_valid++;
      chk("data_dly2", cap_data, d2);
      chk("pix_x", pix_x, {4'b0, cap_data[11:0]});
      chk("pix_y", pix_y, {8'b0, cap_data[15:12]});
      if (int'(pix_x) < min_x) min_x = int'(pix_x);
      if (int'(pix_x) > max_x) max_x = int'(pix_x);
      if (int'(pix_y) < min_y) min_y = int'(pix_y);
      if (int'(pix_y) > max_y) max_y = int'(pix_y);
      if (cap_sof) begin n_sof++; sx = int'(pix_x); sy = int'(pix_y); end
      if (cap_eol) begin n_eol++; eol_x = int'(pix_x); end
      if (cap_eof) begin n_eof++; ex = int'(pix_x); ey = int'(pix_y); end
    end
  end

  task automatic frame(input int short_ln, input int chg_ln,
                       input logic [9:0] chg_x, input int rst_ln);
    int len;
    clear_stats();
    vsync = 1'b1;
    repeat (2) @(negedge vga_clk);
    vsync = 1'b0;
    repeat (3) @(negedge vga_clk);
    for (int y = 0; y < 8; y++) begin
      if (y == chg_ln) win_x = chg_x;
      len = (y == short_ln) ? 15 : 16;
      for (int x = 0; x < len; x++) begin
        rgb_valid = 1'b1;
        rgb = {4'(y), 12'(x)};
        sys_rst = (y == rst_ln && x == 5);
        @(negedge vga_clk);
        if (sys_rst) begin
          sys_rst = 1'b0;
          chk("mrst_valid", cap_valid, 0);
          chk("mrst_flags", {cap_sof, cap_eol, cap_eof}, 0);
          chk("mrst_locked", locked, 0);
          chk("mrst_fmt", fmt_err, 0);
          chk("mrst_hact", h_active, 0);
          chk("mrst_vact", v_active, 0);
          chk("mrst_pix", {pix_x, pix_y}, 0);
          chk("mrst_data", cap_data, 0);
          clear_stats();
        end
      end
      rgb_valid = 1'b0;
      @(negedge vga_clk);
      hsync = 1'b1;
      @(negedge vga_clk);
      hsync = 1'b0;
      repeat (2) @(negedge vga_clk);
    end
    repeat (4) @(negedge vga_clk);
  endtask

  task automatic set_win(input logic [9:0] x, y, w, h);
    win_x = x; win_y = y; win_w = w; win_h = h;
  endtask

  initial begin
    sys_rst = 1'b1; hsync = 1'b0; vsync = 1'b0;
    rgb_valid = 1'b0; rgb = '0; cap_en = 1'b0;
    set_win(0, 0, 0, 0);
    clear_stats();
    repeat (3) @(negedge vga_clk);
    chk("rst_valid", cap_valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_hact", h_active, 0);
    chk("rst_vact", v_active, 0);
    chk("rst_data", cap_data, 0);
    sys_rst = 1'b0;
    cap_en = 1'b1;
    repeat (4) @(negedge vga_clk);

    frame(-1, -1, 0, -1);
    chk("f1_locked", locked, 0);
    chk("f1_valid", n_valid, 0);
    frame(-1, -1, 0, -1);
    chk("f2_locked", locked, 1);
    chk("f2_hact", h_active, 16);
    chk("f2_vact", v_active, 8);
    frame(-1, -1, 0, -1);
    chk("f3_valid", n_valid, 128);
    chk("f3_nsof", n_sof, 1);
    chk("f3_sof_xy", {sx[15:0], sy[15:0]}, {16'd0, 16'd0});
    chk("f3_neof", n_eof, 1);
    chk("f3_eof_xy", {ex[15:0], ey[15:0]}, {16'd15, 16'd7});
    chk("f3_neol", n_eol, 8);

    set_win(4, 2, 3, 2);
    frame(-1, -1, 0, -1);
    chk("win_valid", n_valid, 6);
    chk("win_x_rng", {min_x[15:0], max_x[15:0]}, {16'd4, 16'd6});
    chk("win_y_rng", {min_y[15:0], max_y[15:0]}, {16'd2, 16'd3});
    chk("win_neol", n_eol, 2);
    chk("win_eol_x", eol_x, 6);
    chk("win_sof_xy", {sx[15:0], sy[15:0]}, {16'd4, 16'd2});
    chk("win_eof_xy", {ex[15:0], ey[15:0]}, {16'd6, 16'd3});

    set_win(14, 0, 5, 8);
    frame(-1, -1, 0, -1);
    chk("clip_valid", n_valid, 16);
    chk("clip_x_rng", {min_x[15:0], max_x[15:0]}, {16'd14, 16'd15});
    chk("clip_neol", n_eol, 8);
    chk("clip_eol_x", eol_x, 15);
    chk("clip_neof", n_eof, 1);

    set_win(20, 0, 3, 2);
    frame(-1, -1, 0, -1);
    chk("out_valid", n_valid, 0);
    chk("out_sof", n_sof, 0);

    set_win(0, 0, 0, 0);
    frame(3, -1, 0, -1);
    chk("err_pulse", n_fe, 1);
    chk("err_locked", locked, 0);
    chk("err_valid", n_valid, 63);
    chk("err_neof", n_eof, 0);
    frame(-1, -1, 0, -1);
    chk("meas_valid", n_valid, 0);
    chk("meas_locked", locked, 0);
    chk("meas_fe", n_fe, 0);
    frame(-1, -1, 0, -1);
    chk("relock", locked, 1);
    chk("relock_valid", n_valid, 128);

    set_win(4, 0, 3, 8);
    frame(-1, 3, 10'd8, -1);
    chk("old_win_valid", n_valid, 24);
    chk("old_win_x", {min_x[15:0], max_x[15:0]}, {16'd4, 16'd6});
    frame(-1, -1, 0, -1);
    chk("new_win_valid", n_valid, 24);
    chk("new_win_x", {min_x[15:0], max_x[15:0]}, {16'd8, 16'd10});

    set_win(0, 0, 0, 0);
    frame(-1, -1, 0, 3);
    chk("post_rst_valid", n_valid, 0);
    frame(-1, -1, 0, -1);
    chk("r1_valid", n_valid, 0);
    chk("r1_locked", locked, 0);
    frame(-1, -1, 0, -1);
    chk("r2_locked", locked, 1);
    chk("r2_valid", n_valid, 128);
    chk("r2_hv", {h_active, v_active}, {12'd16, 12'd8});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
